// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, carry held in a flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sacc_q, sacc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Single full-adder stage working on the current LSBs.
  logic fa_s;
  logic fa_c;
  logic last_step;

  assign fa_s      = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_c      = (sa_q[0] & sb_q[0]) | ((sa_q[0] ^ sb_q[0]) & carry_q);
  assign last_step = (cnt_q == LastCnt);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sacc_d  = sacc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = bus.cin;
          sacc_d  = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        sacc_d  = {fa_s, sacc_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (last_step) begin
          sum_d   = sacc_d;
          cout_d  = fa_c;
          // Counter parks at zero so it never exceeds WIDTH-1.
          cnt_d   = '0;
          state_d = StDone;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB is the flop value before this final step.
          ovf_d   = carry_q ^ fa_c;
`endif
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sacc_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sacc_q  <= sacc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // Elaboration-time legality of the configuration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..32");
  end
  if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
    $error("serial_adder: CNT_W too small for WIDTH");
  end

  a_cnt_range : assert property (@(posedge clk) disable iff (rst) cnt_q <= LastCnt);
  a_done_once : assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8 and WIDTH=4 instances)
// against a plain-arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8), .CNT_W(6)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(4), .CNT_W(6)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Unsigned reference: {cout,sum} = a + b + cin.
  function automatic logic [8:0] add_ref(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int w);
    int unsigned s;
    s = (a + b + c) % (1 << (w + 1));
    return 9'(s);
  endfunction

  // Signed reference: true sum outside the w-bit two's-complement range.
  function automatic logic ovf_ref(input int unsigned a, input int unsigned b,
                                   input int unsigned c, input int w);
    int sa, sb, s;
    sa = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    s  = sa + sb + int'(c);
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  // One WIDTH=8 operation; operands are scrambled right after capture.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    int          n = 0;
    int          busy_n = 0;
    logic        seen = 1'b0;
    logic        held = 1'b1;
    logic [7:0]  prev;
    logic [8:0]  exp;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    prev = bus8.sum;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    while (n < 40) begin
      @(negedge clk);
      if (bus8.done) begin seen = 1'b1; break; end
      if (bus8.busy) busy_n++;
      if (bus8.sum !== prev) held = 1'b0;
      n++;
    end
    exp = add_ref(a, b, c, 8);
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_lat"}, 32'(n), 32'd8);
    check_eq({tag, "_busy"}, 32'(busy_n), 32'd8);
    check_eq({tag, "_hold"}, 32'(held), 32'd1);
    check_eq({tag, "_sum"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, exp});
`ifdef SERIAL_ADDER_OVF_EN
    check_eq({tag, "_ovf"}, 32'(bus8.ovf), 32'(ovf_ref(a, b, c, 8)));
`endif
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int         n = 0;
    logic [8:0] exp;
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = c;
    @(posedge clk); #1;
    bus4.start = 1'b0; bus4.a = ~a; bus4.b = ~b;
    while (n < 20 && !bus4.done) begin
      @(negedge clk);
      if (!bus4.done) n++;
    end
    exp = add_ref(a, b, c, 4);
    check_eq("w4_lat", 32'(n), 32'd4);
    check_eq("w4_sum", {27'd0, bus4.cout, bus4.sum}, {27'd0, exp[4:0]});
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("w4_ovf", 32'(bus4.ovf), 32'(ovf_ref(a, b, c, 4)));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          t0;
    int          t1;
    logic        spurious;
    logic [7:0]  ra, rb;
    logic        rc;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus8.busy), 32'd0);
    check_eq("rst_done", 32'(bus8.done), 32'd0);
    check_eq("rst_sum", {23'd0, bus8.cout, bus8.sum}, 32'd0);
    rst = 1'b0;

    op8("basic", 8'h3C, 8'h55, 1'b0);
    op8("chain", 8'hFF, 8'hFF, 1'b1);

    // Reset mid-operation clears everything at once and publishes nothing.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check_eq("mid_rst_done", 32'(bus8.done), 32'd0);
    check_eq("mid_rst_sum", {23'd0, bus8.cout, bus8.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) spurious = 1'b1;
    end
    check_eq("mid_rst_quiet", 32'(spurious), 32'd0);

    // Start during RUN with new operands must be ignored.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
    n = 0;
    while (n < 40 && !bus8.done) begin @(negedge clk); n++; end
    bus8.start = 1'b0;
    check_eq("ign_sum", {23'd0, bus8.cout, bus8.sum}, {23'd0, add_ref(8'h0F, 8'h01, 0, 8)});
    spurious = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) spurious = 1'b1;
    end
    check_eq("ign_no_second", 32'(spurious), 32'd0);

    // Start held high: one result every WIDTH+2 cycles.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.a = 8'h7F; bus8.b = 8'h01;
    n = 0; t0 = -1; t1 = -1;
    while (n < 60 && t1 < 0) begin
      @(negedge clk);
      if (bus8.done && t0 < 0) begin
        t0 = n;
        check_eq("b2b_first", {23'd0, bus8.cout, bus8.sum}, {23'd0, add_ref(8'h80, 8'h80, 0, 8)});
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("b2b_first_ovf", 32'(bus8.ovf), 32'(ovf_ref(8'h80, 8'h80, 0, 8)));
`endif
      end else if (bus8.done) begin
        t1 = n;
        check_eq("b2b_second", {23'd0, bus8.cout, bus8.sum}, {23'd0, add_ref(8'h7F, 8'h01, 0, 8)});
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("b2b_second_ovf", 32'(bus8.ovf), 32'(ovf_ref(8'h7F, 8'h01, 0, 8)));
`endif
      end
      n++;
    end
    bus8.start = 1'b0;
    check_eq("b2b_first_lat", 32'(t0), 32'd8);
    check_eq("b2b_spacing", 32'(t1 - t0), 32'd10);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8("rand", ra, rb, rc);
    end

    for (int k = 0; k < 512; k++) begin
      op4(4'(k), 4'(k >> 4), 1'(k >> 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
